// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register feeding the ALU. Captures decoded operands and
//   control from ID, decodes the 3-bit ALU control at capture time, resolves
//   EX/MEM and MEM/WB forwarding for rs and rt combinationally in EX, and
//   flags load-use hazards for the pipeline controller.
//
//   Ports
//     clk_i, rst_n_i            clock (rising edge), async active-low reset
//     stall_i, flush_i          hold / bubble (flush wins)
//     id_*                      decoded instruction fields from ID
//     exmem_*, memwb_*          forwarding sources from later stages
//     alu_data1_o/2_o/ctrl_o    ALU inputs
//     ex_store_data_o           forwarded rt for stores
//     ex_*                      registered EX-stage control
//     load_use_o                combinational load-use hazard flag

// Per-source forwarding mux: EX/MEM beats MEM/WB, r0 is never forwarded.
module id_ex_fwd_mux #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic [AW-1:0] src_addr,
   input  logic [DW-1:0] reg_data,
   input  logic          exmem_reg_write,
   input  logic [AW-1:0] exmem_rd_addr,
   input  logic [DW-1:0] exmem_data,
   input  logic          memwb_reg_write,
   input  logic [AW-1:0] memwb_rd_addr,
   input  logic [DW-1:0] memwb_data,
   output logic [DW-1:0] fwd_data
);
   logic nz;
   assign nz = (src_addr != '0);

   always_comb begin
      fwd_data = reg_data;
      if (exmem_reg_write && nz && (exmem_rd_addr == src_addr))
         fwd_data = exmem_data;
      else if (memwb_reg_write && nz && (memwb_rd_addr == src_addr))
         fwd_data = memwb_data;
   end
endmodule

module id_ex_operand_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic          id_valid_i,
   input  logic [DW-1:0] id_rs_data_i,
   input  logic [DW-1:0] id_rt_data_i,
   input  logic [DW-1:0] id_imm_i,
   input  logic [AW-1:0] id_rs_addr_i,
   input  logic [AW-1:0] id_rt_addr_i,
   input  logic [AW-1:0] id_rd_addr_i,
   input  logic [1:0]    id_alu_op_i,
   input  logic [5:0]    id_funct_i,
   input  logic          id_alu_src_i,
   input  logic          id_reg_dst_i,
   input  logic          id_reg_write_i,
   input  logic          id_mem_read_i,
   input  logic          id_mem_write_i,
   input  logic          id_mem_to_reg_i,
   input  logic          exmem_reg_write_i,
   input  logic [AW-1:0] exmem_rd_addr_i,
   input  logic [DW-1:0] exmem_data_i,
   input  logic          memwb_reg_write_i,
   input  logic [AW-1:0] memwb_rd_addr_i,
   input  logic [DW-1:0] memwb_data_i,
   output logic [DW-1:0] alu_data1_o,
   output logic [DW-1:0] alu_data2_o,
   output logic [2:0]    alu_ctrl_o,
   output logic [DW-1:0] ex_store_data_o,
   output logic          ex_valid_o,
   output logic [AW-1:0] ex_dest_addr_o,
   output logic          ex_reg_write_o,
   output logic          ex_mem_read_o,
   output logic          ex_mem_write_o,
   output logic          ex_mem_to_reg_o,
   output logic          ex_illegal_o,
   output logic          load_use_o
);
   localparam int NSRC = 2;  // index 0 = rs, 1 = rt

   // control state
   logic          ex_valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
   logic [2:0]    alu_ctrl_q;
   logic          illegal_q;
   // data state (don't-care after a flush, so it simply holds)
   logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
   logic [AW-1:0] rs_addr_q, rt_addr_q, dest_q;
   logic          alu_src_q;

   logic [2:0]    alu_ctrl_d;
   logic          illegal_d;

   always_comb begin
      alu_ctrl_d = 3'b010;
      illegal_d  = 1'b0;
      case (id_alu_op_i)
         2'b00: alu_ctrl_d = 3'b010;
         2'b01: alu_ctrl_d = 3'b110;
         2'b11: alu_ctrl_d = 3'b001;
         default: begin
            case (id_funct_i)
               6'b100000: alu_ctrl_d = 3'b010;
               6'b100010: alu_ctrl_d = 3'b110;
               6'b100100: alu_ctrl_d = 3'b000;
               6'b100101: alu_ctrl_d = 3'b001;
               6'b011000: alu_ctrl_d = 3'b011;
               6'b101010: alu_ctrl_d = 3'b111;
               default: begin
                  alu_ctrl_d = 3'b010;
                  illegal_d  = 1'b1;
               end
            endcase
         end
      endcase
   end

   // Controls are qualified by id_valid_i so a bubble never carries side effects.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ex_valid_q   <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_ctrl_q   <= 3'b000;
         illegal_q    <= 1'b0;
      end else if (flush_i) begin
         ex_valid_q   <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_ctrl_q   <= 3'b000;
         illegal_q    <= 1'b0;
      end else if (!stall_i) begin
         ex_valid_q   <= id_valid_i;
         reg_write_q  <= id_valid_i & id_reg_write_i;
         mem_read_q   <= id_valid_i & id_mem_read_i;
         mem_write_q  <= id_valid_i & id_mem_write_i;
         mem_to_reg_q <= id_valid_i & id_mem_to_reg_i;
         alu_ctrl_q   <= id_valid_i ? alu_ctrl_d : 3'b000;
         illegal_q    <= id_valid_i & illegal_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         dest_q    <= '0;
         alu_src_q <= 1'b0;
      end else if (!flush_i && !stall_i) begin
         rs_data_q <= id_rs_data_i;
         rt_data_q <= id_rt_data_i;
         imm_q     <= id_imm_i;
         rs_addr_q <= id_rs_addr_i;
         rt_addr_q <= id_rt_addr_i;
         dest_q    <= id_reg_dst_i ? id_rd_addr_i : id_rt_addr_i;
         alu_src_q <= id_alu_src_i;
      end
   end

   logic [NSRC-1:0][AW-1:0] src_addr;
   logic [NSRC-1:0][DW-1:0] src_data, fwd_data;

   assign src_addr = {rt_addr_q, rs_addr_q};
   assign src_data = {rt_data_q, rs_data_q};

   for (genvar g = 0; g < NSRC; g++) begin : g_fwd
      id_ex_fwd_mux #(.DW(DW), .AW(AW)) u_fwd (
         .src_addr        (src_addr[g]),
         .reg_data        (src_data[g]),
         .exmem_reg_write (exmem_reg_write_i),
         .exmem_rd_addr   (exmem_rd_addr_i),
         .exmem_data      (exmem_data_i),
         .memwb_reg_write (memwb_reg_write_i),
         .memwb_rd_addr   (memwb_rd_addr_i),
         .memwb_data      (memwb_data_i),
         .fwd_data        (fwd_data[g])
      );
   end

   assign alu_data1_o     = fwd_data[0];
   assign alu_data2_o     = alu_src_q ? imm_q : fwd_data[1];
   assign ex_store_data_o = fwd_data[1];
   assign alu_ctrl_o      = alu_ctrl_q;
   assign ex_valid_o      = ex_valid_q;
   assign ex_dest_addr_o  = dest_q;
   assign ex_reg_write_o  = reg_write_q;
   assign ex_mem_read_o   = mem_read_q;
   assign ex_mem_write_o  = mem_write_q;
   assign ex_mem_to_reg_o = mem_to_reg_q;
   assign ex_illegal_o    = illegal_q;

   // Load in EX whose destination is read by the instruction now in ID.
   assign load_use_o = ex_valid_q & mem_read_q & (rt_addr_q != '0) & id_valid_i &
                       ((rt_addr_q == id_rs_addr_i) | (rt_addr_q == id_rt_addr_i));
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: a spec-level model of the captured
// instruction is checked every falling edge, plus literal expectations per scenario.
module tb_id_ex_operand_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, flush = 1'b0;
   logic        id_valid = 1'b0;
   logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
   logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, id_rd_addr = '0;
   logic [1:0]  id_alu_op = '0;
   logic [5:0]  id_funct = '0;
   logic        id_alu_src = 0, id_reg_dst = 0, id_reg_write = 0, id_mem_read = 0;
   logic        id_mem_write = 0, id_mem_to_reg = 0;
   logic        exmem_rw = 0, memwb_rw = 0;
   logic [4:0]  exmem_rd = '0, memwb_rd = '0;
   logic [31:0] exmem_data = '0, memwb_data = '0;
   logic [31:0] alu_data1, alu_data2, store_data;
   logic [2:0]  alu_ctrl;
   logic        ex_valid, ex_rw, ex_mr, ex_mw, ex_m2r, ex_ill, load_use;
   logic [4:0]  ex_dest;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   id_ex_operand_stage #(.DW(32), .AW(5)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
      .id_valid_i(id_valid), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
      .id_imm_i(id_imm), .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr),
      .id_rd_addr_i(id_rd_addr), .id_alu_op_i(id_alu_op), .id_funct_i(id_funct),
      .id_alu_src_i(id_alu_src), .id_reg_dst_i(id_reg_dst), .id_reg_write_i(id_reg_write),
      .id_mem_read_i(id_mem_read), .id_mem_write_i(id_mem_write),
      .id_mem_to_reg_i(id_mem_to_reg),
      .exmem_reg_write_i(exmem_rw), .exmem_rd_addr_i(exmem_rd), .exmem_data_i(exmem_data),
      .memwb_reg_write_i(memwb_rw), .memwb_rd_addr_i(memwb_rd), .memwb_data_i(memwb_data),
      .alu_data1_o(alu_data1), .alu_data2_o(alu_data2), .alu_ctrl_o(alu_ctrl),
      .ex_store_data_o(store_data), .ex_valid_o(ex_valid), .ex_dest_addr_o(ex_dest),
      .ex_reg_write_o(ex_rw), .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw),
      .ex_mem_to_reg_o(ex_m2r), .ex_illegal_o(ex_ill), .load_use_o(load_use)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'b00) return 3'b010;
      if (op == 2'b01) return 3'b110;
      if (op == 2'b11) return 3'b001;
      case (f)
         6'd32: return 3'b010;   // add
         6'd34: return 3'b110;   // sub
         6'd36: return 3'b000;   // and
         6'd37: return 3'b001;   // or
         6'd24: return 3'b011;   // mul
         6'd42: return 3'b111;   // slt
         default: return 3'b010;
      endcase
   endfunction

   function automatic bit ref_ill(input logic [1:0] op, input logic [5:0] f);
      return (op == 2'b10) && !(f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd24, 6'd42});
   endfunction

   function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d);
      if (a == 0) return d;
      if (exmem_rw && exmem_rd == a) return exmem_data;
      if (memwb_rw && memwb_rd == a) return memwb_data;
      return d;
   endfunction

   // The instruction currently held in EX, as the spec describes it.
   logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_ill, m_src, m_known;
   logic [2:0]  m_ctrl;
   logic [4:0]  m_rs_a, m_rt_a, m_dest;
   logic [31:0] m_rs_d, m_rt_d, m_imm;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {m_valid, m_rw, m_mr, m_mw, m_m2r, m_ill, m_src} <= '0;
         m_ctrl <= 3'b000; m_known <= 1'b1;
         m_rs_a <= '0; m_rt_a <= '0; m_dest <= '0;
         m_rs_d <= '0; m_rt_d <= '0; m_imm <= '0;
      end else if (flush) begin
         {m_valid, m_rw, m_mr, m_mw, m_m2r, m_ill} <= '0;
         m_ctrl <= 3'b000; m_known <= 1'b0;
      end else if (!stall) begin
         m_valid <= id_valid;
         m_rw    <= id_valid && id_reg_write;
         m_mr    <= id_valid && id_mem_read;
         m_mw    <= id_valid && id_mem_write;
         m_m2r   <= id_valid && id_mem_to_reg;
         m_ctrl  <= id_valid ? ref_ctrl(id_alu_op, id_funct) : 3'b000;
         m_ill   <= id_valid && ref_ill(id_alu_op, id_funct);
         m_known <= 1'b1;
         m_src   <= id_alu_src;
         m_rs_a  <= id_rs_addr; m_rt_a <= id_rt_addr;
         m_rs_d  <= id_rs_data; m_rt_d <= id_rt_data; m_imm <= id_imm;
         m_dest  <= id_reg_dst ? id_rd_addr : id_rt_addr;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m.valid", ex_valid, m_valid);
         chk("m.rw", ex_rw, m_rw);
         chk("m.mr", ex_mr, m_mr);
         chk("m.mw", ex_mw, m_mw);
         chk("m.m2r", ex_m2r, m_m2r);
         chk("m.ctrl", alu_ctrl, m_ctrl);
         chk("m.ill", ex_ill, m_ill);
         chk("m.load_use", load_use, m_valid && m_mr && m_rt_a != 0 && id_valid &&
                                     (m_rt_a == id_rs_addr || m_rt_a == id_rt_addr));
         if (m_known) begin
            chk("m.data1", alu_data1, ref_fwd(m_rs_a, m_rs_d));
            chk("m.data2", alu_data2, m_src ? m_imm : ref_fwd(m_rt_a, m_rt_d));
            chk("m.store", store_data, ref_fwd(m_rt_a, m_rt_d));
            chk("m.dest", ex_dest, m_dest);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rsa, input logic [31:0] rsd,
                         input logic [4:0] rta, input logic [31:0] rtd, input logic [4:0] rda,
                         input logic [31:0] imm, input logic [1:0] op, input logic [5:0] f,
                         input logic src, input logic dst, input logic rw, input logic mr,
                         input logic mw, input logic m2r);
      id_valid = v; id_rs_addr = rsa; id_rs_data = rsd; id_rt_addr = rta; id_rt_data = rtd;
      id_rd_addr = rda; id_imm = imm; id_alu_op = op; id_funct = f; id_alu_src = src;
      id_reg_dst = dst; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
      id_mem_to_reg = m2r;
   endtask

   task automatic no_fwd();
      exmem_rw = 0; memwb_rw = 0; exmem_rd = 0; memwb_rd = 0;
   endtask

   logic [5:0] funct_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b011000, 6'b101010};
   logic [2:0] ctrl_tab  [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b111};

   initial begin
      // reset state
      step();
      chk_en = 1'b1;
      #2;
      chk("rst.valid", ex_valid, 0);
      chk("rst.ctrl", alu_ctrl, 3'b000);
      chk("rst.ill", ex_ill, 0);
      chk("rst.data1", alu_data1, 0);
      step();
      rst_n = 1'b1;

      // 1: R-type add, no forwarding
      set_id(1, 5'd5, 32'd7, 5'd6, 32'd3, 5'd10, 32'h0, 2'b10, 6'b100000, 0, 1, 1, 0, 0, 0);
      step();
      chk("t1.data1", alu_data1, 32'd7);
      chk("t1.data2", alu_data2, 32'd3);
      chk("t1.ctrl", alu_ctrl, 3'b010);
      chk("t1.ill", ex_ill, 0);
      chk("t1.dest", ex_dest, 5'd10);

      // 2: double forward on rs (and rt), immediate on operand 2
      set_id(1, 5'd8, 32'h11, 5'd8, 32'h22, 5'd1, 32'h1234, 2'b00, 6'h0, 1, 0, 1, 0, 0, 0);
      step();
      exmem_rw = 1; exmem_rd = 5'd8; exmem_data = 32'hAA;
      memwb_rw = 1; memwb_rd = 5'd8; memwb_data = 32'hBB;
      #1;
      chk("t2.both", alu_data1, 32'hAA);
      chk("t2.imm", alu_data2, 32'h1234);
      chk("t2.store", store_data, 32'hAA);
      exmem_rw = 0;
      #1;
      chk("t2.memwb", alu_data1, 32'hBB);
      chk("t2.store_mw", store_data, 32'hBB);

      // 3: r0 is never forwarded
      set_id(1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 32'h0, 2'b11, 6'h0, 0, 1, 1, 0, 0, 0);
      exmem_rw = 1; exmem_rd = 5'd0; exmem_data = 32'h55;
      memwb_rw = 1; memwb_rd = 5'd0; memwb_data = 32'h66;
      step();
      chk("t3.r0", alu_data1, 32'h0);
      chk("t3.ctrl_or", alu_ctrl, 3'b001);
      no_fwd();

      // 4: load-use detection then flush
      set_id(1, 5'd1, 32'h100, 5'd9, 32'h0, 5'd3, 32'd4, 2'b00, 6'h0, 1, 0, 1, 1, 0, 1);
      step();
      chk("t4.dest", ex_dest, 5'd9);
      chk("t4.data2", alu_data2, 32'd4);
      set_id(1, 5'd3, 32'h0, 5'd4, 32'h0, 5'd5, 32'h0, 2'b10, 6'b100000, 0, 1, 1, 0, 0, 0);
      #1 chk("t4.no_hazard", load_use, 0);
      id_rt_addr = 5'd9;
      #1 chk("t4.hazard_rt", load_use, 1);
      id_rt_addr = 5'd4; id_rs_addr = 5'd9;
      #1 chk("t4.hazard_rs", load_use, 1);
      id_valid = 0;
      #1 chk("t4.id_invalid", load_use, 0);
      id_valid = 1;
      flush = 1;
      step();
      flush = 0;
      chk("t4.valid", ex_valid, 0);
      chk("t4.rw", ex_rw, 0);
      chk("t4.mr", ex_mr, 0);

      // 5: stall holds everything, flush+stall bubbles
      set_id(1, 5'd2, 32'h2, 5'd7, 32'h3, 5'd0, 32'h8, 2'b01, 6'h0, 0, 0, 1, 1, 1, 0);
      step();
      stall = 1;
      set_id(1, 5'd7, 32'h9, 5'd12, 32'h9, 5'd13, 32'h0, 2'b11, 6'h0, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5.valid", ex_valid, 1);
         chk("t5.mr", ex_mr, 1);
         chk("t5.mw", ex_mw, 1);
         chk("t5.ctrl", alu_ctrl, 3'b110);
         chk("t5.dest", ex_dest, 5'd7);
         chk("t5.load_use", load_use, 1);
      end
      flush = 1;
      step();
      flush = 0; stall = 0;
      chk("t5.bubble", ex_valid, 0);
      chk("t5.bubble_mw", ex_mw, 0);
      chk("t5.bubble_lu", load_use, 0);

      // decode table and an invalid slot
      for (int i = 0; i < 6; i++) begin
         set_id(1, 5'd4, 32'h4, 5'd5, 32'h5, 5'd6, 32'h0, 2'b10, funct_tab[i], 0, 1, 1, 0, 0, 0);
         step();
         chk("dec.ctrl", alu_ctrl, ctrl_tab[i]);
         chk("dec.ill", ex_ill, 0);
      end
      set_id(0, 5'd4, 32'h4, 5'd5, 32'h5, 5'd6, 32'h0, 2'b10, 6'b111111, 0, 1, 1, 1, 1, 1);
      step();
      chk("inv.rw", ex_rw, 0);
      chk("inv.ill", ex_ill, 0);

      // 6: illegal funct, then async reset mid-cycle
      set_id(1, 5'd4, 32'h4, 5'd5, 32'h5, 5'd6, 32'h0, 2'b10, 6'b111111, 0, 1, 1, 0, 0, 0);
      step();
      chk("t6.ctrl", alu_ctrl, 3'b010);
      chk("t6.ill", ex_ill, 1);
      #1 rst_n = 0;
      #1;
      chk("t6.rst_ill", ex_ill, 0);
      chk("t6.rst_valid", ex_valid, 0);
      chk("t6.rst_ctrl", alu_ctrl, 3'b000);
      step();
      rst_n = 1;
      set_id(0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 6'h0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
